// File: rtl/fmap_wb_pkg.sv
// Shared constants and state encoding for the feature-map DDR write-back engine.
package fmap_wb_pkg;

  localparam int IN_WIDTH   = 144;
  localparam int OUT_WIDTH  = 256;
  localparam int BUF_WIDTH  = IN_WIDTH + OUT_WIDTH;
  localparam int BEAT_BYTES = OUT_WIDTH / 8;
  localparam int ADDR_WIDTH = 28;
  localparam int CNT_WIDTH  = 16;
  localparam int FILL_WIDTH = $clog2(BUF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fmap_gearbox_144to256.sv
// 144-bit to 256-bit packing gearbox: a 400-bit LSB-first buffer with a bit-level
// fill count. The low 256 bits are always the candidate output beat; everything at
// or above the fill level is kept at zero so a partial final beat is zero-padded.
module fmap_gearbox_144to256
  import fmap_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_fire,
  input  logic                  out_fire,
  output logic [OUT_WIDTH-1:0]  beat_data,
  output logic [FILL_WIDTH-1:0] fill
);

  localparam logic [FILL_WIDTH-1:0] BEAT_FILL = FILL_WIDTH'(OUT_WIDTH);
  localparam logic [FILL_WIDTH-1:0] WORD_FILL = FILL_WIDTH'(IN_WIDTH);

  logic [BUF_WIDTH-1:0]  data_buf_q;
  logic [BUF_WIDTH-1:0]  shifted;
  logic [BUF_WIDTH-1:0]  data_buf_d;
  logic [FILL_WIDTH-1:0] fill_q;
  logic [FILL_WIDTH-1:0] fill_shift;
  logic [FILL_WIDTH-1:0] fill_d;

  // Drop an accepted beat first, then append the incoming word just above what remains,
  // so a word and a beat can move in the same cycle.
  always_comb begin
    shifted    = data_buf_q;
    fill_shift = fill_q;
    if (out_fire) begin
      shifted    = data_buf_q >> OUT_WIDTH;
      fill_shift = (fill_q > BEAT_FILL) ? (fill_q - BEAT_FILL) : '0;
    end
    data_buf_d = shifted;
    fill_d     = fill_shift;
    if (in_fire) begin
      data_buf_d = shifted | ({{OUT_WIDTH{1'b0}}, in_data} << fill_shift);
      fill_d     = fill_shift + WORD_FILL;
    end
  end

  // Buffer and fill registers; cleared on reset and at the start of each frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data_buf_q <= '0;
      fill_q     <= '0;
    end else begin
      data_buf_q <= data_buf_d;
      fill_q     <= fill_d;
    end
  end

  assign beat_data = data_buf_q[OUT_WIDTH-1:0];
  assign fill      = fill_q;

endmodule

// File: rtl/fmap_ddr_writer.sv
// Feature-map write-back engine: packs 144-bit conv output words into 256-bit DDR
// write beats with incrementing byte addresses, one frame per accepted start.
// Build option FMAP_WB_BSWAP_EN: when defined, each output beat is byte-reversed
// for a big-endian DDR host; address, valid and last are unaffected.
module fmap_ddr_writer
  import fmap_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr_in,
  input  logic [CNT_WIDTH-1:0]  cfg_words_in,
  input  logic [IN_WIDTH-1:0]   Conv_data_in,
  input  logic                  Conv_data_valid_in,
  output logic                  Conv_data_ready_out,
  output logic [OUT_WIDTH-1:0]  DDR_data_out,
  output logic                  DDR_valid_out,
  input  logic                  DDR_ready_in,
  output logic [ADDR_WIDTH-1:0] DDR_addr_out,
  output logic                  DDR_last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [FILL_WIDTH-1:0] BEAT_FILL = FILL_WIDTH'(OUT_WIDTH);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  words_left_q;
  logic [FILL_WIDTH-1:0] fill;
  logic [OUT_WIDTH-1:0]  beat_data;
  logic                  start_accept;
  logic                  in_fire;
  logic                  out_fire;

  // Handshakes are decoded only from registered state and fill, so the conv side never
  // sees a path from DDR_ready_in.
  assign start_accept        = start_in && (state_q == IDLE);
  assign Conv_data_ready_out = (state_q == PACK) && (fill <= BEAT_FILL) && (words_left_q != '0);
  assign DDR_valid_out       = (fill >= BEAT_FILL) || ((state_q == FLUSH) && (fill != '0));
  assign DDR_last_out        = DDR_valid_out && (state_q == FLUSH) && (fill <= BEAT_FILL);
  assign in_fire             = Conv_data_valid_in && Conv_data_ready_out;
  assign out_fire            = DDR_valid_out && DDR_ready_in;
  assign DDR_addr_out        = addr_q;
  assign busy_out            = (state_q != IDLE);
  assign done_out            = (state_q == DONE);

  fmap_gearbox_144to256 u_gearbox (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_accept),
    .in_data   (Conv_data_in),
    .in_fire   (in_fire),
    .out_fire  (out_fire),
    .beat_data (beat_data),
    .fill      (fill)
  );

`ifdef FMAP_WB_BSWAP_EN
  // Reverse byte order within the beat for a big-endian host.
  always_comb begin
    DDR_data_out = '0;
    for (int k = 0; k < BEAT_BYTES; k++) begin
      DDR_data_out[8*k +: 8] = beat_data[8*(BEAT_BYTES-1-k) +: 8];
    end
  end
`else
  assign DDR_data_out = beat_data;
`endif

  // Frame sequencing: pack words, drain the remainder, then pulse done for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = (cfg_words_in == '0) ? DONE : PACK;
        end
      end
      PACK: begin
        if (in_fire && (words_left_q == CNT_WIDTH'(1))) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((out_fire && DDR_last_out) || (fill == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the per-frame address and remaining-word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_accept) begin
        addr_q       <= cfg_base_addr_in;
        words_left_q <= cfg_words_in;
      end else begin
        if (out_fire) begin
          addr_q <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
        end
        if (in_fire) begin
          words_left_q <= words_left_q - CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fmap_ddr_writer.sv
// Scoreboard bench for fmap_ddr_writer: frames of random words are turned into expected
// beats by a bit-queue packing model; a negedge monitor compares every accepted beat and
// tracks fill arithmetic to predict ready/valid/last/busy/done every cycle.
// Build option FMAP_WB_BSWAP_EN is mirrored in the expected beat data.
module tb_fmap_ddr_writer;

  localparam int INW  = 144;
  localparam int OUTW = 256;
  localparam int AW   = 28;
  localparam int CW   = 16;

  typedef struct {
    logic [OUTW-1:0] data;
    logic [AW-1:0]   addr;
    logic            last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_in;
  logic [AW-1:0]   cfg_base_addr_in;
  logic [CW-1:0]   cfg_words_in;
  logic [INW-1:0]  Conv_data_in;
  logic            Conv_data_valid_in;
  logic            Conv_data_ready_out;
  logic [OUTW-1:0] DDR_data_out;
  logic            DDR_valid_out;
  logic            DDR_ready_in;
  logic [AW-1:0]   DDR_addr_out;
  logic            DDR_last_out;
  logic            busy_out;
  logic            done_out;

  beat_t          exp_q[$];
  logic [INW-1:0] word_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int accepted_cnt = 0;
  int ready_mode = 0;
  int feed_mode = 0;
  bit toggle = 1'b0;

  int  fill_m = 0;
  int  wl_m = 0;
  bit  active_m = 1'b0;
  bit  done_m = 1'b0;
  bit  prev_stall = 1'b0;
  logic [OUTW-1:0] prev_data;
  logic [AW-1:0]   prev_addr;

  always #5 clk = ~clk;

  fmap_ddr_writer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start_in            (start_in),
    .cfg_base_addr_in    (cfg_base_addr_in),
    .cfg_words_in        (cfg_words_in),
    .Conv_data_in        (Conv_data_in),
    .Conv_data_valid_in  (Conv_data_valid_in),
    .Conv_data_ready_out (Conv_data_ready_out),
    .DDR_data_out        (DDR_data_out),
    .DDR_valid_out       (DDR_valid_out),
    .DDR_ready_in        (DDR_ready_in),
    .DDR_addr_out        (DDR_addr_out),
    .DDR_last_out        (DDR_last_out),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  task automatic checkOutput(input string name, input logic [OUTW-1:0] actual,
                             input logic [OUTW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [INW-1:0] makeWord(input int pat, input int idx);
    logic [INW-1:0] w;
    logic [159:0]   r;
    case (pat)
      1: w = {18{8'hAB}};
      2: begin
        w = '0;
        w[15:0]  = 16'h0102;
        w[31:16] = 16'(idx);
      end
      default: begin
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        w = r[INW-1:0];
      end
    endcase
    return w;
  endfunction

  // Reference model: concatenate word bits LSB-first, cut into zero-padded 256-bit beats.
  task automatic buildFrame(input logic [AW-1:0] base, input int words, input int pat);
    bit             bitq[$];
    logic [INW-1:0] w;
    logic [OUTW-1:0] tmp;
    beat_t          b;
    int             nbeats;
    for (int i = 0; i < words; i++) begin
      w = makeWord(pat, i);
      word_q.push_back(w);
      for (int k = 0; k < INW; k++) bitq.push_back(w[k]);
    end
    nbeats = (words * INW + OUTW - 1) / OUTW;
    for (int i = 0; i < nbeats; i++) begin
      b.data = '0;
      for (int k = 0; k < OUTW; k++) begin
        if (bitq.size() > 0) b.data[k] = bitq.pop_front();
      end
`ifdef FMAP_WB_BSWAP_EN
      tmp = b.data;
      for (int k = 0; k < OUTW/8; k++) b.data[8*k +: 8] = tmp[8*(OUTW/8-1-k) +: 8];
`else
      tmp = '0;
`endif
      b.addr = base + AW'(i * 32);
      b.last = (i == nbeats - 1);
      exp_q.push_back(b);
    end
    accepted_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulseStart(input logic [AW-1:0] base, input int words);
    @(posedge clk); #2;
    start_in = 1'b1;
    cfg_base_addr_in = base;
    cfg_words_in = CW'(words);
    @(posedge clk); #2;
    start_in = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) checkOutput({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    checkOutput({name, "_done_once"}, OUTW'(done_cnt), 1);
    checkOutput({name, "_beats_left"}, OUTW'(exp_q.size()), 0);
    checkOutput({name, "_words_left"}, OUTW'(word_q.size()), 0);
  endtask

  task automatic applyStimulus(input string name, input logic [AW-1:0] base, input int words,
                               input int pat, input int fmode, input int rmode,
                               input bit extra_start);
    feed_mode = fmode;
    ready_mode = rmode;
    buildFrame(base, words, pat);
    pulseStart(base, words);
    if (extra_start) begin
      @(posedge clk); #2;
      start_in = 1'b1;
      cfg_base_addr_in = 28'h0ABCDE0;
      cfg_words_in = 16'd5;
      @(posedge clk); #2;
      start_in = 1'b0;
    end
    waitDone(name);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_valid"}, OUTW'(DDR_valid_out), 0);
    checkOutput({name, "_addr"}, OUTW'(DDR_addr_out), 0);
    checkOutput({name, "_data"}, DDR_data_out, 0);
    checkOutput({name, "_last"}, OUTW'(DDR_last_out), 0);
    checkOutput({name, "_busy"}, OUTW'(busy_out), 0);
    checkOutput({name, "_done"}, OUTW'(done_out), 0);
    checkOutput({name, "_ready"}, OUTW'(Conv_data_ready_out), 0);
  endtask

  // DDR sink backpressure: always ready, alternating, or random.
  initial begin
    DDR_ready_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: DDR_ready_in = 1'b1;
        1: begin
          toggle = ~toggle;
          DDR_ready_in = toggle;
        end
        default: DDR_ready_in = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Conv source: presents the head of word_q, pops it once accepted.
  initial begin
    bit fire;
    Conv_data_valid_in = 1'b0;
    Conv_data_in = '0;
    forever begin
      @(negedge clk);
      fire = !rst && Conv_data_valid_in && Conv_data_ready_out;
      @(posedge clk);
      if (fire && word_q.size() > 0) begin
        void'(word_q.pop_front());
        accepted_cnt++;
      end
      #1;
      if (word_q.size() > 0 && (feed_mode == 0 || $urandom_range(0, 99) < 70)) begin
        Conv_data_valid_in = 1'b1;
        Conv_data_in = word_q[0];
      end else begin
        Conv_data_valid_in = 1'b0;
        Conv_data_in = '0;
      end
    end
  end

  // Monitor: per-cycle handshake model from fill arithmetic, scoreboard on accepted beats.
  always @(negedge clk) begin
    bit    ready_exp, valid_exp, last_exp, in_fire, out_fire, done_n;
    int    f;
    beat_t b;
    if (rst) begin
      fill_m = 0; wl_m = 0; active_m = 1'b0; done_m = 1'b0; prev_stall = 1'b0;
    end else begin
      ready_exp = active_m && (wl_m > 0) && (fill_m <= 256);
      valid_exp = (fill_m >= 256) || (active_m && wl_m == 0 && fill_m > 0);
      last_exp  = valid_exp && active_m && (wl_m == 0) && (fill_m <= 256);
      checkOutput("conv_ready", OUTW'(Conv_data_ready_out), OUTW'(ready_exp));
      checkOutput("ddr_valid", OUTW'(DDR_valid_out), OUTW'(valid_exp));
      checkOutput("ddr_last", OUTW'(DDR_last_out), OUTW'(last_exp));
      checkOutput("busy", OUTW'(busy_out), OUTW'(active_m || done_m));
      checkOutput("done", OUTW'(done_out), OUTW'(done_m));
      if (prev_stall) begin
        checkOutput("hold_valid", OUTW'(DDR_valid_out), 1);
        checkOutput("hold_data", DDR_data_out, prev_data);
        checkOutput("hold_addr", OUTW'(DDR_addr_out), OUTW'(prev_addr));
      end
      in_fire  = Conv_data_valid_in && Conv_data_ready_out;
      out_fire = DDR_valid_out && DDR_ready_in;
      if (out_fire) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_data", DDR_data_out, b.data);
          checkOutput("beat_addr", OUTW'(DDR_addr_out), OUTW'(b.addr));
          checkOutput("beat_last", OUTW'(DDR_last_out), OUTW'(b.last));
        end
      end
      if (done_out) done_cnt++;
      done_n = 1'b0;
      if (start_in && !busy_out) begin
        if (cfg_words_in == '0) done_n = 1'b1;
        else begin
          active_m = 1'b1;
          wl_m = int'(cfg_words_in);
          fill_m = 0;
        end
      end else if (active_m) begin
        f = fill_m;
        if (out_fire) begin
          if (wl_m == 0 && fill_m <= 256) begin
            active_m = 1'b0;
            done_n = 1'b1;
          end
          f = (f > 256) ? f - 256 : 0;
        end
        if (in_fire) begin
          f += 144;
          wl_m--;
        end
        fill_m = f;
      end
      done_m = done_n;
      prev_stall = DDR_valid_out && !DDR_ready_in;
      prev_data = DDR_data_out;
      prev_addr = DDR_addr_out;
    end
  end

  initial begin
    int n;
    logic [31:0] r;
    rst = 1'b1;
    start_in = 1'b0;
    cfg_base_addr_in = '0;
    cfg_words_in = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    applyStimulus("full16", 28'h0001000, 16, 0, 0, 0, 1'b0);
    applyStimulus("single_ab", 28'h0002340, 1, 1, 0, 0, 1'b0);
    applyStimulus("toggle16", 28'h0001000, 16, 0, 0, 1, 1'b0);
    applyStimulus("zero_words", 28'h0003000, 0, 0, 0, 0, 1'b0);
    applyStimulus("busy_start", 28'h0004000, 4, 0, 0, 0, 1'b1);

    // Abort a frame after five words with a mid-frame reset.
    feed_mode = 0;
    ready_mode = 0;
    buildFrame(28'h0005000, 10, 0);
    pulseStart(28'h0005000, 10);
    n = 0;
    while (accepted_cnt < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (accepted_cnt < 5) checkOutput("abort_wait_timeout", 0, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    word_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkAllZero("mid_reset");
    @(posedge clk); #2;
    rst = 1'b0;
    applyStimulus("after_reset2", 28'h0006000, 2, 0, 0, 0, 1'b0);

    applyStimulus("addr_wrap", 28'hFFFFFC0, 8, 0, 1, 2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      applyStimulus("random", r[AW-1:0], $urandom_range(1, 24), 0,
                    $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
    end
    applyStimulus("pattern0102", 28'h0007000, 1, 2, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_ddr_writer.md
Name: fmap_ddr_writer

Overview:
Feature-map write-back engine: accepts 144-bit conv output words (9 lanes x 16-bit) from the conv datapath and packs them LSB-first into 256-bit DDR write beats with byte addresses. It is the write-side counterpart of the 256-bit DDR read path that feeds the weight memory, and closes the layer loop from conv output back to DDR. One frame (layer) per start pulse.

Parameters:
IN_WIDTH, 144, conv output word width
OUT_WIDTH, 256, DDR beat width
ADDR_WIDTH, 28, DDR byte address width
CNT_WIDTH, 16, input word count width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start_in  in  1  one-cycle frame start; ignored while busy_out=1
cfg_base_addr_in  in  ADDR_WIDTH  frame byte base address, sampled on accepted start
cfg_words_in  in  CNT_WIDTH  input words in frame, sampled on accepted start
Conv_data_in  in  IN_WIDTH  conv output word
Conv_data_valid_in  in  1  word valid
Conv_data_ready_out  out  1  word accepted when valid&ready
DDR_data_out  out  OUT_WIDTH  write beat
DDR_valid_out  out  1  beat valid; held with data/addr stable until DDR_ready_in
DDR_ready_in  in  1  DDR accepts beat
DDR_addr_out  out  ADDR_WIDTH  beat byte address
DDR_last_out  out  1  final beat of frame
busy_out  out  1  frame in progress
done_out  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Single clock clk; rst synchronous active-high. On rst: all outputs 0, buffer cleared, fill=0, state IDLE. rst mid-frame aborts; no pending beat is re-issued.
- States: IDLE -> (start_in) PACK -> (last input accepted) FLUSH -> (last beat accepted) DONE -> IDLE. start with cfg_words_in=0: IDLE -> DONE directly, no beats, done_out next cycle.
- Buffer 400 bits (OUT_WIDTH+IN_WIDTH), fill in bits; bits at/above fill always zero.
- Conv_data_ready_out = (state==PACK) && (fill <= 256) && (words_left > 0). Registered-equivalent: depends on state/fill only, never on DDR_ready_in.
- Accepted word written at bit offset fill' = fill - 256*out_fire; fill_next = fill - 256*out_fire + 144*in_fire. Simultaneous in/out fire in one cycle is legal and required.
- DDR_valid_out = (fill >= 256) || (state==FLUSH && fill > 0). DDR_data_out = buf[255:0] (partial beat zero-padded). On out_fire buffer shifts right 256 with zero fill; in FLUSH a partial beat drains fill to 0.
- DDR_addr_out = base + 32*beat_idx; beat_idx resets on start, increments on out_fire. Address wraps modulo 2^ADDR_WIDTH.
- Beats per frame = ceil(words*144/256). 16 words -> exactly 9 beats, no padding.
- DDR_last_out = DDR_valid_out && beat is final (FLUSH and fill<=256).
- busy_out=1 from cycle after accepted start until DONE; done_out high exactly one cycle in DONE.
- Latency: first beat valid earliest 2 cycles after 2nd word accepted.
- No combinational path input->output except none; all outputs from registers.

Optional Feature:
FMAP_WB_BSWAP_EN: defined -> DDR_data_out byte-reversed per beat (byte k <- byte 31-k) for big-endian DDR host; undefined -> native LSB-first order. Affects data only, not addr/valid/last.

Decomposition:
- Package fmap_wb_pkg: IN_WIDTH/OUT_WIDTH/BUF_WIDTH(400)/BEAT_BYTES(32) constants, state enum (IDLE, PACK, FLUSH, DONE).
- Sub-module fmap_gearbox_144to256: buffer, fill counter, insert/shift, padding; top holds FSM, counters, address.

Test Plan:
- start base=0x1000, words=16, valid every cycle, DDR_ready=1 -> 9 beats, addrs 0x1000..0x1100 step 0x20, last on 9th, done_out once, data equals concatenated inputs.
- words=1, word=all 0xAB bytes -> 1 beat, bits[143:0]=0xAB.., bits[255:144]=0, last=1, addr=base.
- words=16, DDR_ready toggles 1/0 each cycle -> data/addr held while stalled, Conv_ready drops when fill>256, output identical to first test.
- words=0 -> no DDR_valid, done_out 1 cycle after start; start during busy ignored.
- rst asserted after 5 words -> next cycle all outputs 0; new start words=2 -> 2 beats (288 bits: 256 + 32 padded).
- FMAP_WB_BSWAP_EN defined, words=1 word=0x..0102 -> DDR_data_out[255:240]=0x0201.
